// File: rtl/noc_pkg.sv
// Shared constants for the NoC output-port slice: packet width, input indices
// and the sent-packet counter width.
package noc_pkg;
  localparam int PAC_WIDTH_DEF = 64;
  localparam int IN0           = 0;
  localparam int IN1           = 1;
  localparam int PKT_CNT_W     = 16;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. It owns the priority bit, and the priority bit
// moves to the losing side after every grant.
module rr_arbiter2
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[IN0] && req[IN1]) begin
        gnt = prio ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // Priority only moves when something was granted; it then favours the other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (gnt[IN0]) begin
      prio <= 1'b1;
    end else if (gnt[IN1]) begin
      prio <= 1'b0;
    end
  end
endmodule

// File: rtl/out_port_ctrl.sv
// Output port controller: arbitrates two one-slot upstream buffers into a single
// registered output stage. Define OUT_PKT_CNT_EN to add the saturating pkt_cnt port.
module out_port_ctrl
  import noc_pkg::*;
#(
  parameter int PAC_WIDTH = PAC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in0_empty,
  input  logic                 in1_empty,
  input  logic [PAC_WIDTH-1:0] in0_data,
  input  logic [PAC_WIDTH-1:0] in1_data,
  output logic                 in0_ren,
  output logic                 in1_ren,
  input  logic                 ri,
  output logic                 so,
  output logic [PAC_WIDTH-1:0] dout
`ifdef OUT_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_cnt
`endif
);
  logic       out_valid;
  logic       free;
  logic       arb_en;
  logic [1:0] req;
  logic [1:0] gnt;

  // The stage accepts a new packet whenever it is empty or is being drained this cycle.
  assign free   = ~out_valid | ri;
  assign arb_en = free & ~reset;
  assign req    = {~in1_empty, ~in0_empty};
  assign so     = out_valid & ri & ~reset;
  assign in0_ren = gnt[IN0];
  assign in1_ren = gnt[IN1];

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (arb_en),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (free) begin
      if (|gnt) begin
        out_valid <= 1'b1;
        dout      <= gnt[IN1] ? in1_data : in0_data;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef OUT_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt <= '0;
    end else if (so && (pkt_cnt != {PKT_CNT_W{1'b1}})) begin
      pkt_cnt <= pkt_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl. The bench acts as both upstream one-slot
// buffers and predicts grants and sends from the arbitration rules.
module tb_out_port_ctrl;
  import noc_pkg::*;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in0_empty = 1'b1;
  logic         in1_empty = 1'b1;
  logic [W-1:0] in0_data = '0;
  logic [W-1:0] in1_data = '0;
  logic         in0_ren;
  logic         in1_ren;
  logic         ri = 1'b0;
  logic         so;
  logic [W-1:0] dout;
`ifdef OUT_PKT_CNT_EN
  logic [15:0]  pkt_cnt;
`endif

  always #5 clk = ~clk;

  out_port_ctrl #(.PAC_WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in0_empty (in0_empty),
    .in1_empty (in1_empty),
    .in0_data  (in0_data),
    .in1_data  (in1_data),
    .in0_ren   (in0_ren),
    .in1_ren   (in1_ren),
    .ri        (ri),
    .so        (so),
    .dout      (dout)
`ifdef OUT_PKT_CNT_EN
    ,
    .pkt_cnt   (pkt_cnt)
`endif
  );

  int vectors = 0;
  int n_checks = 0;
  int miscompares = 0;

  // Reference model: packet held in the output slot, the favoured input, the bench buffers.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] sent_log[$];
  bit           m_valid;
  logic [W-1:0] m_dout;
  int           m_favour;
  int           m_cnt;
  bit           bf[2];
  logic [W-1:0] bd[2];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input bit r);
    bit exp_so;
    bit fr;
    int g;
    @(posedge clk);
    #1;
    reset     = rst;
    ri        = r;
    in0_empty = !bf[0];
    in1_empty = !bf[1];
    in0_data  = bd[0];
    in1_data  = bd[1];
    #1;
    exp_so = !rst && m_valid && r;
    fr     = !m_valid || r;
    g      = -1;
    if (!rst && fr) begin
      if (bf[0] && bf[1]) g = m_favour;
      else if (bf[0])     g = 0;
      else if (bf[1])     g = 1;
    end
    check("so", 64'(so), 64'(exp_so));
    check("in0_ren", 64'(in0_ren), 64'(g == 0));
    check("in1_ren", 64'(in1_ren), 64'(g == 1));
    check("dout", dout, m_dout);
`ifdef OUT_PKT_CNT_EN
    check("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
`endif
    vectors++;
    if (exp_so && m_cnt < 65535) m_cnt++;
    if (rst) begin
      m_valid  = 0;
      m_dout   = '0;
      m_favour = 0;
      m_cnt    = 0;
      exp_q.delete();
    end else if (g >= 0) begin
      m_valid  = 1;
      m_dout   = bd[g];
      m_favour = 1 - g;
      exp_q.push_back(bd[g]);
      bf[g]    = 0;
    end else if (fr) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    bf[0] = 0;
    bf[1] = 0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    sent_log.delete();
  endtask

  task automatic refill(input int pct);
    for (int k = 0; k < 2; k++) begin
      if (!bf[k] && $urandom_range(0, 99) < pct) begin
        bf[k] = 1;
        bd[k] = {$urandom, $urandom};
      end
    end
  endtask

  // Monitor: every send must match the oldest accepted, not yet sent packet.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (so === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_send: got dout %0h, required no send", dout);
        end else begin
          e = exp_q.pop_front();
          if (dout !== e) begin
            miscompares++;
            $display("FAIL send_data: got %0h, required %0h", dout, e);
          end
        end
        sent_log.push_back(dout);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hits;
    // Single input, first send one cycle after the grant.
    do_reset();
    bf[0] = 1; bd[0] = 64'hA5;
    step(1'b0, 1'b1);
    check("a5_ren", 64'(in0_ren), 64'd1);
    step(1'b0, 1'b1);
    check("a5_so", 64'(so), 64'd1);
    check("a5_dout", dout, 64'hA5);

    // Both requesting: order 1 then 2.
    do_reset();
    bf[0] = 1; bd[0] = 64'h1;
    bf[1] = 1; bd[1] = 64'h2;
    repeat (4) step(1'b0, 1'b1);
    check("rr_count", 64'(sent_log.size()), 64'd2);
    if (sent_log.size() == 2) begin
      check("rr_first", sent_log[0], 64'h1);
      check("rr_second", sent_log[1], 64'h2);
    end

    // Backpressure: hold 0x33 for three cycles, then one send plus reload.
    do_reset();
    bf[0] = 1; bd[0] = 64'h33;
    step(1'b0, 1'b0);
    bf[1] = 1; bd[1] = 64'h44;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("bp_so", 64'(so), 64'd0);
      check("bp_ren1", 64'(in1_ren), 64'd0);
      check("bp_dout", dout, 64'h33);
    end
    repeat (3) step(1'b0, 1'b1);
    hits = 0;
    foreach (sent_log[i]) if (sent_log[i] == 64'h33) hits++;
    check("bp_single_send", 64'(hits), 64'd1);

    // Reset while the stage holds a packet: it is discarded.
    do_reset();
    bf[0] = 1; bd[0] = 64'h77;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    check("rst_so", 64'(so), 64'd0);
    step(1'b0, 1'b1);
    check("rst_dout", dout, 64'd0);
    bf[0] = 1; bd[0] = 64'h10;
    bf[1] = 1; bd[1] = 64'h11;
    step(1'b0, 1'b1);
    check("rst_prio0", 64'(in0_ren), 64'd1);
    repeat (4) step(1'b0, 1'b1);
    hits = 0;
    foreach (sent_log[i]) if (sent_log[i] == 64'h77) hits++;
    check("rst_discard", 64'(hits), 64'd0);

    // Only input 1 with prio 0: granted, priority returns to input 0.
    do_reset();
    bf[1] = 1; bd[1] = 64'h55;
    step(1'b0, 1'b1);
    check("solo1_ren", 64'(in1_ren), 64'd1);
    bf[0] = 1; bd[0] = 64'h60;
    bf[1] = 1; bd[1] = 64'h61;
    step(1'b0, 1'b1);
    check("solo1_next_ren0", 64'(in0_ren), 64'd1);
    repeat (4) step(1'b0, 1'b1);

    // Randomized traffic with backpressure and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      refill(60);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end
    bf[0] = 0; bf[1] = 0;
    repeat (3) step(1'b0, 1'b1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

`ifdef OUT_PKT_CNT_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bf[0] = 1; bd[0] = 64'(i + 1);
      step(1'b0, 1'b1);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("cnt_five", 64'(pkt_cnt), 64'd5);
    for (int i = 0; i < 65540; i++) begin
      bf[0] = 1; bd[0] = 64'(i);
      step(1'b0, 1'b1);
    end
    bf[0] = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("cnt_sat", 64'(pkt_cnt), 64'hFFFF);
`endif

    step(1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
